// File: rtl/main_mem_initiator_if.sv
// Command, upstream data, response and main-memory bus bundle for main_mem_initiator.
interface main_mem_initiator_if #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int LW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wdata;
  logic          wdata_pop;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          done;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, wdata, mem_ack, mem_rdata,
    output cmd_ready, wdata_pop, rsp_valid, rsp_data, done, err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, wdata, mem_ack, mem_rdata,
    input  cmd_ready, wdata_pop, rsp_valid, rsp_data, done, err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/main_mem_initiator.sv
// Main-memory bus master: req rises the cycle after command accept, one beat per acked cycle, read data
// returned one cycle after ack; mem_ack stalls hold the beat, and a watchdog aborts after TIMEOUT idle cycles.
module main_mem_initiator #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int LW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic scan_in0,
  input  logic scan_in1,
  input  logic scan_in2,
  input  logic scan_in3,
  input  logic scan_in4,
  input  logic scan_enable,
  input  logic test_mode,
  output logic scan_out0,
  output logic scan_out1,
  output logic scan_out2,
  output logic scan_out3,
  output logic scan_out4,
  main_mem_initiator_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } cmd_t;

  logic [1:0]    state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [LW-1:0] beat_q, beat_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          done_q, done_d;

  logic in_bus;
  logic beat_ack;
  logic wr_bus;

  assign in_bus   = (state_q == BUS);
  assign beat_ack = in_bus & bus.mem_ack;
  assign wr_bus   = in_bus & cmd_q.we;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    done_d      = 1'b0;
    case (state_q)
      BUS: begin
        if (bus.mem_ack) begin
          cmd_d.addr = cmd_q.addr + AW'(1);
          tmo_d      = '0;
          if (!cmd_q.we) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus.mem_rdata;
          end
          if (beat_q == cmd_q.len) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + LW'(1);
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
          // an ack in the expiring cycle still wins over the abort
          if (tmo_q + 8'd1 == TMO_LIMIT) begin
            state_d = ERR;
          end
        end
      end
      default: begin
        // IDLE and the one-cycle ERR both accept a new command
        state_d = IDLE;
        if (bus.cmd_valid) begin
          cmd_d.we   = bus.cmd_we;
          cmd_d.addr = bus.cmd_addr;
          cmd_d.len  = bus.cmd_len;
          beat_d     = '0;
          tmo_d      = '0;
          state_d    = BUS;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      beat_q      <= '0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      done_q      <= done_d;
    end
  end

  assign bus.cmd_ready = (state_q != BUS);
  assign bus.mem_req   = in_bus;
  assign bus.mem_we    = wr_bus;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = wr_bus ? bus.wdata : '0;
  assign bus.wdata_pop = beat_ack & cmd_q.we;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.done      = done_q;
  assign bus.err       = (state_q == ERR);

  // scan chains are stitched at synthesis
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  logic unused_scan;
  assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode};
endmodule

// File: tb/tb_main_mem_initiator.sv
// Directed and randomised bench for main_mem_initiator with a transaction-level reference model.
module tb_main_mem_initiator;
  localparam int AW      = 8;
  localparam int DW      = 16;
  localparam int LW      = 4;
  localparam int TIMEOUT = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic scan_in0 = 1'b0, scan_in1 = 1'b0, scan_in2 = 1'b0, scan_in3 = 1'b0, scan_in4 = 1'b0;
  logic scan_enable = 1'b0;
  logic test_mode   = 1'b0;
  logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

  main_mem_initiator_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();

  main_mem_initiator #(.AW(AW), .DW(DW), .LW(LW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
    .scan_in3(scan_in3), .scan_in4(scan_in4),
    .scan_enable(scan_enable), .test_mode(test_mode),
    .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
    .scan_out3(scan_out3), .scan_out4(scan_out4),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem_arr [256];
  logic [DW-1:0] wsrc [64];
  int            wptr;

  logic          nx_valid, nx_we;
  logic [AW-1:0] nx_addr;
  logic [LW-1:0] nx_len;
  int            ack_mode, ack_gap, ack_den, req_age;

  // reference model: one outstanding burst plus the pulses due next cycle
  bit            m_busy, m_we;
  logic [AW-1:0] m_addr;
  int            m_left, m_quiet;
  bit            p_rsp, p_done, p_err;
  logic [DW-1:0] p_data;

  int            n_req_hi, n_rsp, n_done, n_err, n_pop, n_rsp_done;
  logic [DW-1:0] rsp_q[$];
  logic [AW-1:0] ack_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rsp_at(input int i);
    return (i < rsp_q.size()) ? 32'(rsp_q[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ack_at(input int i);
    return (i < ack_q.size()) ? 32'(ack_q[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic clr_obs();
    n_req_hi = 0; n_rsp = 0; n_done = 0; n_err = 0; n_pop = 0; n_rsp_done = 0;
    rsp_q.delete();
    ack_q.delete();
  endtask

  task automatic cyc();
    @(negedge clk);
    bus.cmd_valid = nx_valid;
    bus.cmd_we    = nx_we;
    bus.cmd_addr  = nx_addr;
    bus.cmd_len   = nx_len;
    case (ack_mode)
      1:       bus.mem_ack = bus.mem_req && (req_age >= ack_gap);
      2:       bus.mem_ack = ($urandom_range(ack_den - 1, 0) == 0);
      default: bus.mem_ack = 1'b0;
    endcase
    bus.mem_rdata = mem_arr[bus.mem_addr];
    bus.wdata     = wsrc[wptr];
    scan_in0 = 1'($urandom); scan_in1 = 1'($urandom); scan_in2 = 1'($urandom);
    scan_in3 = 1'($urandom); scan_in4 = 1'($urandom); scan_enable = 1'($urandom);
    #1;
    chk("mem_req",   32'(bus.mem_req),   32'(m_busy));
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy));
    chk("wdata_pop", 32'(bus.wdata_pop), 32'(m_busy && m_we && bus.mem_ack));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(p_rsp));
    chk("done",      32'(bus.done),      32'(p_done));
    chk("err",       32'(bus.err),       32'(p_err));
    if (p_rsp) chk("rsp_data", 32'(bus.rsp_data), 32'(p_data));
    if (m_busy) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      chk("mem_we",   32'(bus.mem_we),   32'(m_we));
      if (m_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(wsrc[wptr]));
    end
    // observations taken from the DUT, used by the directed literal checks
    if (bus.mem_req) n_req_hi++;
    if (bus.rsp_valid) begin n_rsp++; rsp_q.push_back(bus.rsp_data); end
    if (bus.done) n_done++;
    if (bus.err) n_err++;
    if (bus.rsp_valid && bus.done) n_rsp_done++;
    if (bus.wdata_pop) n_pop++;
    if (bus.mem_req && bus.mem_ack) begin
      ack_q.push_back(bus.mem_addr);
      if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
    end
    // advance the model across the coming rising edge
    p_rsp = 0; p_done = 0; p_err = 0;
    if (m_busy) begin
      if (bus.mem_ack) begin
        if (!m_we) begin p_rsp = 1; p_data = bus.mem_rdata; end
        else wptr = (wptr + 1) % 64;
        m_addr  = m_addr + 1'b1;
        m_left  = m_left - 1;
        m_quiet = 0;
        if (m_left == 0) begin m_busy = 0; p_done = 1; end
      end else begin
        m_quiet = m_quiet + 1;
        if (m_quiet == TIMEOUT) begin m_busy = 0; p_err = 1; end
      end
    end else if (bus.cmd_valid) begin
      m_busy  = 1;
      m_we    = bus.cmd_we;
      m_addr  = bus.cmd_addr;
      m_left  = int'(bus.cmd_len) + 1;
      m_quiet = 0;
    end
    if (bus.mem_req && !bus.mem_ack) req_age++;
    else req_age = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.mem_ack   = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_mem_req",   32'(bus.mem_req),   32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_done",      32'(bus.done),      32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    chk("rst_wdata_pop", 32'(bus.wdata_pop), 32'd0);
    chk("rst_scan_out",  32'({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}), 32'd0);
    m_busy = 0; p_rsp = 0; p_done = 0; p_err = 0; req_age = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [LW-1:0] l);
    nx_valid = 1'b1; nx_we = we; nx_addr = a; nx_len = l;
    cyc();
    nx_valid = 1'b0;
  endtask

  task automatic wait_end(input string nm, input int budget);
    int start = n_done + n_err;
    int k = 0;
    while (n_done + n_err == start && k < budget) begin
      cyc();
      k++;
    end
    chk(nm, 32'(n_done + n_err > start), 32'd1);
  endtask

  initial begin
    bus.cmd_valid = 0; bus.cmd_we = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wdata = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
    nx_valid = 0; nx_we = 0; nx_addr = '0; nx_len = '0;
    ack_mode = 0; ack_gap = 0; ack_den = 1; req_age = 0; wptr = 0;
    m_busy = 0; m_we = 0; m_addr = '0; m_left = 0; m_quiet = 0;
    p_rsp = 0; p_done = 0; p_err = 0; p_data = '0;
    foreach (mem_arr[i]) mem_arr[i] = '0;
    foreach (wsrc[i]) wsrc[i] = '0;
    clr_obs();
    do_reset();

    // single read, ack two cycles after req
    clr_obs();
    mem_arr[8'h10] = 16'hBEEF;
    ack_mode = 1; ack_gap = 2;
    issue(1'b0, 8'h10, 4'd0);
    wait_end("rd1_end", 40);
    chk("rd1_nrsp", n_rsp, 1);
    chk("rd1_data", rsp_at(0), 32'h0000_BEEF);
    chk("rd1_rsp_with_done", n_rsp_done, 1);
    chk("rd1_addr", ack_at(0), 32'h10);
    chk("rd1_req_cycles", n_req_hi, 3);

    // write burst across the address wrap, ack every cycle
    clr_obs();
    wptr = 0;
    wsrc[0] = 16'h1111; wsrc[1] = 16'h2222; wsrc[2] = 16'h3333; wsrc[3] = 16'h4444;
    ack_gap = 0;
    issue(1'b1, 8'hFE, 4'd3);
    wait_end("wr_end", 40);
    chk("wr_mem_fe", 32'(mem_arr[8'hFE]), 32'h1111);
    chk("wr_mem_ff", 32'(mem_arr[8'hFF]), 32'h2222);
    chk("wr_mem_00", 32'(mem_arr[8'h00]), 32'h3333);
    chk("wr_mem_01", 32'(mem_arr[8'h01]), 32'h4444);
    chk("wr_pops", n_pop, 4);
    chk("wr_done", n_done, 1);

    // stalled read burst, five idle cycles before each ack
    clr_obs();
    mem_arr[8'h40] = 16'hA1A1; mem_arr[8'h41] = 16'hB2B2; mem_arr[8'h42] = 16'hC3C3;
    ack_gap = 5;
    issue(1'b0, 8'h40, 4'd2);
    wait_end("stall_end", 100);
    chk("stall_nrsp", n_rsp, 3);
    chk("stall_d0", rsp_at(0), 32'hA1A1);
    chk("stall_d1", rsp_at(1), 32'hB2B2);
    chk("stall_d2", rsp_at(2), 32'hC3C3);
    chk("stall_err", n_err, 0);
    chk("stall_req_cycles", n_req_hi, 18);

    // watchdog: memory never acks
    clr_obs();
    ack_mode = 0;
    issue(1'b0, 8'h80, 4'd0);
    wait_end("tmo_end", 60);
    chk("tmo_req_cycles", n_req_hi, 15);
    chk("tmo_err", n_err, 1);
    chk("tmo_done", n_done, 0);
    clr_obs();
    ack_mode = 1; ack_gap = 0;
    issue(1'b1, 8'h81, 4'd0);
    wait_end("tmo_next_end", 20);
    chk("tmo_next_done", n_done, 1);
    chk("tmo_next_addr", ack_at(0), 32'h81);

    // reset in the middle of a long read burst
    clr_obs();
    issue(1'b0, 8'h20, 4'd7);
    for (int k = 0; k < 20 && ack_q.size() < 3; k++) cyc();
    chk("midrst_acks", ack_q.size(), 3);
    do_reset();
    clr_obs();
    mem_arr[8'h55] = 16'h5A5A;
    issue(1'b0, 8'h55, 4'd0);
    wait_end("midrst_next_end", 20);
    chk("midrst_next_addr", ack_at(0), 32'h55);
    chk("midrst_next_data", rsp_at(0), 32'h5A5A);

    // random commands, random (including stray) acks, occasional resets
    foreach (mem_arr[i]) mem_arr[i] = DW'($urandom);
    foreach (wsrc[i]) wsrc[i] = DW'($urandom);
    ack_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        case ($urandom_range(3, 0))
          0:       ack_den = 1;
          1:       ack_den = 2;
          2:       ack_den = 4;
          default: ack_den = 12;
        endcase
      end
      nx_valid = ($urandom_range(3, 0) == 0);
      nx_we    = 1'($urandom);
      nx_addr  = AW'($urandom);
      nx_len   = LW'($urandom);
      cyc();
      if ($urandom_range(499, 0) == 0) do_reset();
    end
    nx_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
